// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder: a chain of 1-bit full-adder cells
// feeding a result register with carry-out, signed-overflow and zero flags.

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ c;
  assign co = (a & b) | (c & p);

endmodule

module full_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  // carry[i] is the carry into cell i; carry[WIDTH] leaves the MSB cell.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;
  logic             ovf_c;
  logic             zero_c;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .c  (carry[i]),
      .s  (sum_c[i]),
      .co (carry[i+1])
    );
  end

  // For WIDTH=1 carry[WIDTH-1] is carry[0], i.e. cin, so no special case is needed.
  assign ovf_c  = carry[WIDTH] ^ carry[WIDTH-1];
  assign zero_c = (sum_c == '0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b1;
    end else begin
      out_valid <= in_valid;
      // Result registers only move on a qualified input, so unqualified
      // (possibly unknown) operands never reach the outputs.
      if (in_valid) begin
        s    <= sum_c;
        cout <= carry[WIDTH];
        ovf  <= ovf_c;
        zero <= zero_c;
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Directed + exhaustive bench for full_adder (WIDTH=4) with a queue scoreboard
// filled at stimulus time and drained when out_valid presents a result.

module tb_full_adder;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;
  logic         zero;

  res_t q[$];
  res_t last;
  int   vectors = 0;
  int   miscompares = 0;

  full_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c);
    res_t       r;
    logic [W:0] t;
    t      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    r.s    = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    r.zero = (t[W-1:0] == '0);
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag);
    check({tag, ".s"},    8'(s),    8'(last.s));
    check({tag, ".cout"}, 8'(cout), 8'(last.cout));
    check({tag, ".ovf"},  8'(ovf),  8'(last.ovf));
    check({tag, ".zero"}, 8'(zero), 8'(last.zero));
  endtask

  // Drive one cycle of stimulus at negedge, then inspect the result after the edge.
  task automatic step(input string tag, input logic v, input logic [W-1:0] ta,
                      input logic [W-1:0] tb, input logic tc);
    @(negedge clk);
    in_valid = v;
    a        = ta;
    b        = tb;
    cin      = tc;
    if (v) q.push_back(model(ta, tb, tc));
    @(posedge clk);
    #1;
    check({tag, ".out_valid"}, 8'(out_valid), 8'(v));
    if (out_valid) begin
      if (q.size() == 0) begin
        check({tag, ".spurious_result"}, 8'd1, 8'd0);
      end else begin
        last = q.pop_front();
      end
    end
    check_result(tag);
  endtask

  task automatic set_reset_expect();
    last.s    = '0;
    last.cout = 1'b0;
    last.ovf  = 1'b0;
    last.zero = 1'b1;
    q.delete();
  endtask

  initial begin
    // Reset asserted before any clock edge: outputs must clear asynchronously.
    #2;
    in_valid = 1'b1;
    a        = W'($urandom);
    b        = W'($urandom);
    cin      = 1'($urandom);
    rst      = 1'b1;
    #1;
    set_reset_expect();
    check("rst_async.out_valid", 8'(out_valid), 8'd0);
    check_result("rst_async");

    // Valid inputs while reset is held are dropped.
    @(posedge clk);
    #1;
    check("rst_hold.out_valid", 8'(out_valid), 8'd0);
    check_result("rst_hold");
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;

    step("idle0", 1'b0, W'($urandom), W'($urandom), 1'b1);
    step("idle1", 1'b0, 4'b1111, 4'b1111, 1'b1);

    step("zero_add",  1'b1, 4'b0000, 4'b0000, 1'b0);
    step("b2b_0",     1'b1, 4'b1011, 4'b0100, 1'b0);
    step("b2b_1",     1'b1, 4'b1011, 4'b0100, 1'b0);
    step("all_carry", 1'b1, 4'b1111, 4'b1101, 1'b1);
    step("pos_ovf",   1'b1, 4'b0111, 4'b0001, 1'b0);
    step("neg_ovf",   1'b1, 4'b1000, 4'b1000, 1'b0);

    for (int i = 0; i < 3; i++) step("hold", 1'b0, W'($urandom), W'($urandom), 1'($urandom));

    // Mid-stream reset: lands between edges with a valid operation pending.
    step("pre_rst", 1'b1, 4'b0110, 4'b0011, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    a        = 4'b0101;
    b        = 4'b0101;
    cin      = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    set_reset_expect();
    check("rst_mid.out_valid", 8'(out_valid), 8'd0);
    check_result("rst_mid");
    @(posedge clk);
    #1;
    check("rst_mid_edge.out_valid", 8'(out_valid), 8'd0);
    check_result("rst_mid_edge");
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;

    step("post_rst", 1'b1, 4'b0001, 4'b0010, 1'b0);

    // Exhaustive back-to-back sweep of every {a, b, cin}.
    for (int v = 0; v < 512; v++) begin
      logic [8:0] vec;
      vec = 9'(v);
      step("sweep", 1'b1, vec[8:5], vec[4:1], vec[0]);
    end
    step("sweep_end", 1'b0, 4'b0000, 4'b0000, 1'b0);

    check("scoreboard_empty", 8'(q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
